// File: rtl/mmu_tlb_translator_if.sv
// Signal bundle around the translator: CPU request side, page-table read port
// and the cache-controller request side. "slave" is the translator's view.
interface mmu_tlb_translator_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_vaddr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_done;
    logic        cpu_fault;
    logic        tlb_flush;
    logic [31:0] ptbr;
    logic        ptw_req;
    logic [31:0] ptw_addr;
    logic        ptw_ready;
    logic [31:0] ptw_data;
    logic [31:0] cache_phy_addr;
    logic [31:0] cache_wdata;
    logic        cache_read;
    logic        cache_write;
    logic [31:0] cache_rdata;
    logic        cache_stall;

    modport master (
        output cpu_req, cpu_we, cpu_vaddr, cpu_wdata, tlb_flush, ptbr,
               ptw_ready, ptw_data, cache_rdata, cache_stall,
        input  cpu_rdata, cpu_done, cpu_fault, ptw_req, ptw_addr,
               cache_phy_addr, cache_wdata, cache_read, cache_write
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_vaddr, cpu_wdata, tlb_flush, ptbr,
               ptw_ready, ptw_data, cache_rdata, cache_stall,
        output cpu_rdata, cpu_done, cpu_fault, ptw_req, ptw_addr,
               cache_phy_addr, cache_wdata, cache_read, cache_write
    );
endinterface

// File: rtl/mmu_tlb_translator.sv
// Virtual-to-physical translation in front of the cache controller: fully
// associative TLB, round-robin refill, single-level page-table walk on a miss.
module mmu_tlb_translator #(
    parameter int TLB_ENTRIES = 8,
    parameter int PAGE_BITS   = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mmu_tlb_translator_if.slave  bus
);
    localparam int VPN_W = 32 - PAGE_BITS;
    localparam int PTR_W = $clog2(TLB_ENTRIES);

    typedef enum logic [3:0] {
        IDLE, LOOKUP, WALK_REQ, WALK_WAIT, FILL, ISSUE, WAIT_CACHE, DONE, FAULT
    } state_t;

    state_t state, state_next;

    logic [31:0]            vaddr_q;
    logic [31:0]            wdata_q;
    logic                   we_q;
    logic [VPN_W-1:0]       pte_ppn_q;
    logic                   pte_wr_q;
    logic                   pte_valid_q;
    logic [PTR_W-1:0]       rr_ptr;
    logic [TLB_ENTRIES-1:0] tlb_valid;
    logic [TLB_ENTRIES-1:0] tlb_wr;
    logic [VPN_W-1:0]       tlb_vpn [TLB_ENTRIES];
    logic [VPN_W-1:0]       tlb_ppn [TLB_ENTRIES];
    logic [31:0]            ptw_addr_q;
    logic [31:0]            phy_addr_q;
    logic [31:0]            cache_wdata_q;

    logic [VPN_W-1:0]       vpn;
    logic [VPN_W-1:0]       hit_ppn;
    logic                   hit;
    logic                   hit_wr;
    logic [31:0]            pte_addr;
    logic [31:0]            issue_pa;
    logic                   ptbr_unused;

    assign vpn      = vaddr_q[31:PAGE_BITS];
    assign pte_addr = {bus.ptbr[31:PAGE_BITS], {PAGE_BITS{1'b0}}}
                    + {{(PAGE_BITS-2){1'b0}}, vpn, 2'b00};
    // Low table-base bits are architecturally ignored.
    assign ptbr_unused = ^bus.ptbr[PAGE_BITS-1:0];
    assign issue_pa = (state == FILL) ? {pte_ppn_q, vaddr_q[PAGE_BITS-1:0]}
                                      : {hit_ppn,   vaddr_q[PAGE_BITS-1:0]};

    always_comb begin
        // NOTE: every signal written here gets a default first, otherwise a path that skips the assignment infers a latch.
        hit     = 1'b0;
        hit_wr  = 1'b0;
        hit_ppn = '0;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            if (tlb_valid[i] && (tlb_vpn[i] == vpn)) begin
                hit     = 1'b1;
                hit_wr  = tlb_wr[i];
                hit_ppn = tlb_ppn[i];
            end
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (!bus.tlb_flush && bus.cpu_req && !bus.cache_stall)
                            state_next = LOOKUP;
            LOOKUP:     if (!hit)                 state_next = WALK_REQ;
                        else if (!we_q || hit_wr) state_next = ISSUE;
                        else                      state_next = FAULT;
            WALK_REQ:   state_next = WALK_WAIT;
            WALK_WAIT:  if (bus.ptw_ready) state_next = FILL;
            FILL:       if (pte_valid_q && (!we_q || pte_wr_q)) state_next = ISSUE;
                        else                                    state_next = FAULT;
            ISSUE:      state_next = WAIT_CACHE;
            WAIT_CACHE: if (!bus.cache_stall) state_next = DONE;
            DONE:       state_next = IDLE;
            FAULT:      state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.cpu_done       = (state == DONE);
        bus.cpu_fault      = (state == FAULT);
        bus.ptw_req        = (state == WALK_REQ);
        bus.cache_read     = (state == ISSUE) && !we_q;
        bus.cache_write    = (state == ISSUE) &&  we_q;
        bus.cpu_rdata      = bus.cache_rdata;
        bus.ptw_addr       = ptw_addr_q;
        bus.cache_phy_addr = phy_addr_q;
        bus.cache_wdata    = cache_wdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vaddr_q       <= '0;
            wdata_q       <= '0;
            we_q          <= 1'b0;
            pte_ppn_q     <= '0;
            pte_wr_q      <= 1'b0;
            pte_valid_q   <= 1'b0;
            rr_ptr        <= '0;
            tlb_valid     <= '0;
            ptw_addr_q    <= '0;
            phy_addr_q    <= '0;
            cache_wdata_q <= '0;
        end else begin
            if (state == IDLE && state_next == LOOKUP) begin
                vaddr_q <= bus.cpu_vaddr;
                wdata_q <= bus.cpu_wdata;
                we_q    <= bus.cpu_we;
            end
            if (state == IDLE && bus.tlb_flush) begin
                tlb_valid <= '0;
                rr_ptr    <= '0;
            end
            if (state == LOOKUP && !hit) ptw_addr_q <= pte_addr;
            if (state == WALK_WAIT && bus.ptw_ready) begin
                pte_ppn_q   <= bus.ptw_data[31:PAGE_BITS];
                pte_wr_q    <= bus.ptw_data[1];
                pte_valid_q <= bus.ptw_data[0];
            end
            if (state == FILL && pte_valid_q) begin
                tlb_valid[rr_ptr] <= 1'b1;
                rr_ptr            <= rr_ptr + PTR_W'(1);
            end
            if (state_next == ISSUE) begin
                phy_addr_q    <= issue_pa;
                cache_wdata_q <= wdata_q;
            end
        end
    end

    // NOTE: TLB payload has no reset; entries are qualified by tlb_valid, which is reset.
    always_ff @(posedge clk) begin
        if (state == FILL && pte_valid_q) begin
            tlb_vpn[rr_ptr] <= vpn;
            tlb_ppn[rr_ptr] <= pte_ppn_q;
            tlb_wr[rr_ptr]  <= pte_wr_q;
        end
    end
endmodule

// File: tb/tb_mmu_tlb_translator.sv
// Directed bench for mmu_tlb_translator: walks, hits, permissions, invalid
// PTEs, round-robin eviction, flush priority and reset during a walk.
module tb_mmu_tlb_translator;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    mmu_tlb_translator_if bus();

    mmu_tlb_translator #(.TLB_ENTRIES(8), .PAGE_BITS(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Observations of the latest access, cycle numbers counted from the accept cycle (0).
    int          r_walk_n, r_ready_n, r_issue_n, r_done_n, r_fault_n;
    int          r_ptw_cnt, r_rd_cnt, r_wr_cnt;
    logic [31:0] r_walk_addr, r_phy, r_wd, r_rdata;
    logic        r_phy_stable, r_extra;

    function automatic logic [100:0] all_outputs();
        return {bus.cpu_done, bus.cpu_fault, bus.ptw_req, bus.cache_read,
                bus.cache_write, bus.ptw_addr, bus.cache_phy_addr, bus.cache_wdata};
    endfunction

    function automatic logic [31:0] va_of(input logic [19:0] vpn, input logic [11:0] off);
        return {vpn, off};
    endfunction

    // Drives one CPU access and plays the page-table and cache sides.
    task automatic run_access(input logic we, input logic [31:0] vaddr,
                              input logic [31:0] wdata, input logic [31:0] pte,
                              input logic with_flush);
        int n = 0;
        bit fin = 0;
        r_walk_n = -1; r_ready_n = -1; r_issue_n = -1; r_done_n = -1; r_fault_n = -1;
        r_ptw_cnt = 0; r_rd_cnt = 0; r_wr_cnt = 0;
        r_walk_addr = '0; r_phy = '0; r_wd = '0; r_rdata = '0;
        r_phy_stable = 1'b1; r_extra = 1'b0;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_vaddr = vaddr; bus.cpu_wdata = wdata;
        if (with_flush) begin
            bus.tlb_flush = 1'b1;
            @(negedge clk);
            bus.tlb_flush = 1'b0;
        end
        while (!fin && n < 60) begin
            @(negedge clk);
            n++;
            bus.ptw_ready = 1'b0;
            if (bus.ptw_req) begin
                r_ptw_cnt++;
                if (r_walk_n < 0) begin r_walk_n = n; r_walk_addr = bus.ptw_addr; end
            end
            if (r_walk_n >= 0 && n == r_walk_n + 1) begin
                bus.ptw_ready = 1'b1; bus.ptw_data = pte; r_ready_n = n;
            end
            if (bus.cache_read || bus.cache_write) begin
                r_rd_cnt += int'(bus.cache_read);
                r_wr_cnt += int'(bus.cache_write);
                if (r_issue_n < 0) begin
                    r_issue_n = n; r_phy = bus.cache_phy_addr; r_wd = bus.cache_wdata;
                end
                bus.cache_stall = 1'b1;
            end else if (r_issue_n >= 0 && r_done_n < 0) begin
                if (bus.cache_phy_addr !== r_phy) r_phy_stable = 1'b0;
                if (n == r_issue_n + 3) begin
                    bus.cache_stall = 1'b0;
                    bus.cache_rdata = vaddr ^ 32'hA5A5_0000;
                end
            end
            if (bus.cpu_done) begin r_done_n = n; r_rdata = bus.cpu_rdata; fin = 1; end
            if (bus.cpu_fault) begin r_fault_n = n; fin = 1; end
        end
        bus.cpu_req = 1'b0;
        bus.cache_stall = 1'b0;
        if (!fin) begin
            n_checks++; n_fail++;
            $display("FAIL access_timeout: vaddr %h got no completion within 60 cycles", vaddr);
        end
        @(negedge clk);
        r_extra = bus.cpu_done | bus.cpu_fault | bus.cache_read | bus.cache_write | bus.ptw_req;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (all_outputs() !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", all_outputs()); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (all_outputs() !== '0) begin n_fail++; $display("FAIL idle_outputs: got %h want 0", all_outputs()); end
    endtask

    task automatic test_cold_read();
        logic [31:0] va = 32'h0000_5ABC;
        run_access(1'b0, va, 32'h0, 32'h0008_8001, 1'b0);
        n_checks++; if (r_walk_n !== 2) begin n_fail++; $display("FAIL cold_walk_latency: got %0d want 2", r_walk_n); end
        n_checks++; if (r_walk_addr !== 32'h0001_0014) begin n_fail++; $display("FAIL cold_walk_addr: got %h want 00010014", r_walk_addr); end
        n_checks++; if (r_ptw_cnt !== 1) begin n_fail++; $display("FAIL cold_ptw_pulse: got %0d cycles want 1", r_ptw_cnt); end
        n_checks++; if (r_issue_n !== r_ready_n + 2) begin n_fail++; $display("FAIL cold_issue_latency: got %0d want %0d", r_issue_n, r_ready_n + 2); end
        n_checks++; if (r_rd_cnt !== 1 || r_wr_cnt !== 0) begin n_fail++; $display("FAIL cold_req_kind: got rd=%0d wr=%0d want rd=1 wr=0", r_rd_cnt, r_wr_cnt); end
        n_checks++; if (r_phy !== 32'h0008_8ABC) begin n_fail++; $display("FAIL cold_phy: got %h want 00088abc", r_phy); end
        n_checks++; if (r_phy_stable !== 1'b1) begin n_fail++; $display("FAIL cold_phy_hold: got %b want 1", r_phy_stable); end
        n_checks++; if (r_done_n !== r_issue_n + 4) begin n_fail++; $display("FAIL cold_done_timing: got %0d want %0d", r_done_n, r_issue_n + 4); end
        n_checks++; if (r_rdata !== (va ^ 32'hA5A5_0000)) begin n_fail++; $display("FAIL cold_rdata: got %h want %h", r_rdata, va ^ 32'hA5A5_0000); end
        n_checks++; if (r_extra !== 1'b0) begin n_fail++; $display("FAIL cold_single_pulse: got %b want 0", r_extra); end
    endtask

    task automatic test_hit_read();
        run_access(1'b0, 32'h0000_5FF0, 32'h0, 32'h0, 1'b0);
        n_checks++; if (r_ptw_cnt !== 0) begin n_fail++; $display("FAIL hit_no_walk: got %0d walks want 0", r_ptw_cnt); end
        n_checks++; if (r_issue_n !== 2) begin n_fail++; $display("FAIL hit_latency: got %0d want 2", r_issue_n); end
        n_checks++; if (r_phy !== 32'h0008_8FF0) begin n_fail++; $display("FAIL hit_phy: got %h want 00088ff0", r_phy); end
    endtask

    task automatic test_write_perm();
        logic [31:0] wd = 32'hDEAD_BEEF;
        run_access(1'b1, 32'h0000_6004, wd, 32'h0009_9001, 1'b0);
        n_checks++; if (r_fault_n !== r_ready_n + 2) begin n_fail++; $display("FAIL ro_fill_fault: got %0d want %0d", r_fault_n, r_ready_n + 2); end
        n_checks++; if (r_rd_cnt + r_wr_cnt !== 0) begin n_fail++; $display("FAIL ro_no_cache: got %0d requests want 0", r_rd_cnt + r_wr_cnt); end
        run_access(1'b1, 32'h0000_6008, wd, 32'h0, 1'b0);
        n_checks++; if (r_ptw_cnt !== 0 || r_fault_n !== 2) begin n_fail++; $display("FAIL ro_hit_fault: got walks=%0d fault@%0d want walks=0 fault@2", r_ptw_cnt, r_fault_n); end
        run_access(1'b0, 32'h0000_6010, 32'h0, 32'h0, 1'b0);
        n_checks++; if (r_rd_cnt !== 1 || r_phy !== 32'h0009_9010) begin n_fail++; $display("FAIL ro_read_ok: got rd=%0d phy=%h want rd=1 phy=00099010", r_rd_cnt, r_phy); end
        run_access(1'b1, 32'h0000_7123, wd, 32'h0009_9003, 1'b0);
        n_checks++; if (r_wr_cnt !== 1 || r_rd_cnt !== 0) begin n_fail++; $display("FAIL rw_write: got wr=%0d rd=%0d want wr=1 rd=0", r_wr_cnt, r_rd_cnt); end
        n_checks++; if (r_wd !== wd) begin n_fail++; $display("FAIL rw_wdata: got %h want %h", r_wd, wd); end
        n_checks++; if (r_phy !== 32'h0009_9123) begin n_fail++; $display("FAIL rw_phy: got %h want 00099123", r_phy); end
        run_access(1'b1, 32'h0000_7200, 32'h1234_5678, 32'h0, 1'b0);
        n_checks++; if (r_issue_n !== 2 || r_wd !== 32'h1234_5678) begin n_fail++; $display("FAIL rw_hit_write: got issue@%0d wdata=%h want issue@2 wdata=12345678", r_issue_n, r_wd); end
    endtask

    task automatic test_invalid_pte();
        run_access(1'b0, 32'h0001_0040, 32'h0, 32'h0000_0000, 1'b0);
        n_checks++; if (r_fault_n !== r_ready_n + 2 || r_rd_cnt !== 0) begin n_fail++; $display("FAIL inv_fault: got fault@%0d rd=%0d want fault@%0d rd=0", r_fault_n, r_rd_cnt, r_ready_n + 2); end
        n_checks++; if (r_walk_addr !== 32'h0001_0040) begin n_fail++; $display("FAIL inv_walk_addr: got %h want 00010040", r_walk_addr); end
        run_access(1'b0, 32'h0001_0040, 32'h0, 32'h0000_0000, 1'b0);
        n_checks++; if (r_walk_n !== 2) begin n_fail++; $display("FAIL inv_no_fill: got walk@%0d want walk@2", r_walk_n); end
    endtask

    task automatic test_replacement();
        logic [19:0] vpn;
        // Start from an empty TLB so the pointer is known to be 0.
        @(negedge clk); bus.tlb_flush = 1'b1;
        @(negedge clk); bus.tlb_flush = 1'b0;
        for (int v = 0; v < 9; v++) begin
            vpn = 20'(v);
            run_access(1'b0, va_of(vpn, 12'h010), 32'h0, {20'h00100 + vpn, 12'h001}, 1'b0);
            n_checks++; if (r_walk_n !== 2) begin n_fail++; $display("FAIL rr_fill_vpn%0d: got walk@%0d want walk@2", v, r_walk_n); end
        end
        run_access(1'b0, va_of(20'h0, 12'h010), 32'h0, 32'h0010_0001, 1'b0);
        n_checks++; if (r_walk_n !== 2) begin n_fail++; $display("FAIL rr_vpn0_evicted: got walk@%0d want walk@2", r_walk_n); end
        n_checks++; if (r_phy !== 32'h0010_0010) begin n_fail++; $display("FAIL rr_vpn0_phy: got %h want 00100010", r_phy); end
        run_access(1'b0, va_of(20'h8, 12'h010), 32'h0, 32'h0, 1'b0);
        n_checks++; if (r_ptw_cnt !== 0 || r_phy !== 32'h0010_8010) begin n_fail++; $display("FAIL rr_vpn8_hit: got walks=%0d phy=%h want walks=0 phy=00108010", r_ptw_cnt, r_phy); end
        run_access(1'b0, va_of(20'h7, 12'h010), 32'h0, 32'h0, 1'b0);
        n_checks++; if (r_ptw_cnt !== 0 || r_phy !== 32'h0010_7010) begin n_fail++; $display("FAIL rr_vpn7_hit: got walks=%0d phy=%h want walks=0 phy=00107010", r_ptw_cnt, r_phy); end
    endtask

    task automatic test_flush();
        // Flush and request together: flush wins, request accepted one cycle later.
        run_access(1'b0, va_of(20'h8, 12'h020), 32'h0, 32'h0010_8001, 1'b1);
        n_checks++; if (r_walk_n !== 2) begin n_fail++; $display("FAIL flush_vpn8_miss: got walk@%0d want walk@2", r_walk_n); end
        run_access(1'b0, va_of(20'h7, 12'h020), 32'h0, 32'h0010_7001, 1'b0);
        n_checks++; if (r_walk_n !== 2 || r_walk_addr !== 32'h0001_001C) begin n_fail++; $display("FAIL flush_vpn7_miss: got walk@%0d addr=%h want walk@2 addr=0001001c", r_walk_n, r_walk_addr); end
    endtask

    task automatic test_reset_mid_walk();
        bit saw = 0;
        logic bad = 1'b0;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_vaddr = 32'h0002_0123;
        for (int i = 0; i < 10 && !saw; i++) begin
            @(negedge clk);
            if (bus.ptw_req) saw = 1;
        end
        n_checks++; if (!saw) begin n_fail++; $display("FAIL rst_walk_start: got no ptw_req want ptw_req"); end
        @(negedge clk);
        rst_n = 1'b0;
        bus.cpu_req = 1'b0;
        #1;
        n_checks++; if (all_outputs() !== '0) begin n_fail++; $display("FAIL rst_walk_outputs: got %h want 0", all_outputs()); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.ptw_ready = 1'b1; bus.ptw_data = 32'h0077_7001;
        @(negedge clk);
        bus.ptw_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            bad |= bus.cpu_done | bus.cpu_fault | bus.ptw_req | bus.cache_read | bus.cache_write;
        end
        n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL rst_late_ready: got activity=%b want 0", bad); end
        run_access(1'b0, va_of(20'h8, 12'h010), 32'h0, 32'h0010_8001, 1'b0);
        n_checks++; if (r_walk_n !== 2 || r_walk_addr !== 32'h0001_0020) begin n_fail++; $display("FAIL rst_tlb_cleared: got walk@%0d addr=%h want walk@2 addr=00010020", r_walk_n, r_walk_addr); end
        n_checks++; if (r_phy !== 32'h0010_8010) begin n_fail++; $display("FAIL rst_refill_phy: got %h want 00108010", r_phy); end
    endtask

    initial begin
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_vaddr = '0; bus.cpu_wdata = '0;
        bus.tlb_flush = 1'b0; bus.ptbr = 32'h0001_0ABC;
        bus.ptw_ready = 1'b0; bus.ptw_data = '0;
        bus.cache_rdata = '0; bus.cache_stall = 1'b0;
        test_reset();
        test_cold_read();
        test_hit_read();
        test_write_perm();
        test_invalid_pte();
        test_replacement();
        test_flush();
        test_reset_mid_walk();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mmu_tlb_translator.md
Name: mmu_tlb_translator

Overview:
- Translation stage directly upstream of the cache controller; converts CPU virtual addresses to the 32-bit physical addresses the cache consumes.
- Contains a small fully-associative TLB with round-robin replacement.
- On a TLB miss, performs a single-level page-table walk over a dedicated 32-bit PTE read port.
- Issues one read/write request to the cache controller, then waits for the cache's stall signal to drop before completing to the CPU.

Parameters:
TLB_ENTRIES, 8, number of fully-associative TLB entries (power of 2, 2..32)
PAGE_BITS, 12, page offset width (4 KB pages); VPN/PPN = 32-PAGE_BITS = 20 bits

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  level request; held until cpu_done or cpu_fault
cpu_we  in  1  1=write, 0=read; valid with cpu_req
cpu_vaddr  in  32  virtual address
cpu_wdata  in  32  write data
cpu_rdata  out  32  combinational passthrough of cache_rdata
cpu_done  out  1  one-cycle completion pulse
cpu_fault  out  1  one-cycle page-fault pulse; no cache access performed
tlb_flush  in  1  invalidate all TLB entries
ptbr  in  32  page-table base; bits [PAGE_BITS-1:0] ignored (treated as 0)
ptw_req  out  1  one-cycle PTE read request
ptw_addr  out  32  PTE address
ptw_ready  in  1  PTE data valid
ptw_data  in  32  PTE: [31:12]=PPN, [1]=writable, [0]=valid
cache_phy_addr  out  32  physical address to cache controller
cache_wdata  out  32  write data to cache controller
cache_read  out  1  read request pulse
cache_write  out  1  write request pulse
cache_rdata  in  32  cache data_to_cpu
cache_stall  in  1  cache ready_stall (0=ready)

Behaviour:
- Reset (async, any state): state=IDLE; all TLB valid bits=0; round-robin pointer=0; cpu_done, cpu_fault, ptw_req, cache_read, cache_write = 0; ptw_addr, cache_phy_addr, cache_wdata = 0. Reset mid-walk abandons the walk; a late ptw_ready is ignored in IDLE.
- Address split:
  - VPN = vaddr[31:12], offset = vaddr[11:0].
  - PA = {PPN, offset}.
  - PTE address = {ptbr[31:12],12'b0} + {VPN,2'b00}, 32-bit, wrap-around discarded.
- States:
  - IDLE:
    - If tlb_flush: clear all valid bits and reset the pointer to 0; stay in IDLE. Flush has priority over cpu_req for that cycle.
    - Else if cpu_req and cache_stall==0: latch vaddr/we/wdata and go to LOOKUP.
    - tlb_flush outside IDLE is ignored.
  - LOOKUP:
    - Compare latched VPN against all valid entries. At most one match is guaranteed, because fills occur only on a miss.
    - Hit and (read or writable): go to ISSUE.
    - Hit, write, not writable: go to FAULT.
    - Miss: go to WALK_REQ.
  - WALK_REQ: ptw_req=1 for exactly one cycle with ptw_addr; go to WALK_WAIT.
  - WALK_WAIT: hold ptw_addr; on ptw_ready, latch ptw_data and go to FILL. No timeout.
  - FILL:
    - PTE valid=0: go to FAULT; TLB unchanged.
    - Else: write {VPN, PPN, writable} into the entry at the pointer and set its valid bit. Pointer increments modulo TLB_ENTRIES (TLB_ENTRIES-1 wraps to 0).
    - Then apply the same permission check as LOOKUP: go to ISSUE or FAULT.
  - ISSUE:
    - cache_read = ~we or cache_write = we, for exactly one cycle.
    - cache_phy_addr and cache_wdata are driven from this cycle and held stable through WAIT_CACHE.
    - Go to WAIT_CACHE.
  - WAIT_CACHE: on cache_stall==0, go to DONE.
  - DONE: cpu_done=1 for one cycle. cpu_rdata is valid this cycle for reads (cache data is registered). Go to IDLE.
  - FAULT: cpu_fault=1 for one cycle; no cache request; go to IDLE.
- Latency from the cycle cpu_req is accepted in IDLE:
  - TLB hit: cache request pulse at +2 cycles.
  - Miss: ptw_req at +2; cache request 2 cycles after ptw_ready.
- A new request is accepted no earlier than the cycle after cpu_done/cpu_fault, while cpu_req is still high. The CPU must drop cpu_req on completion to avoid a repeat access.
- Out-of-range parameter values are not supported.

Test Plan:
- Cold read: ptbr=0x0001_0000, vaddr=0x0000_5ABC, PTE@0x0001_0014=0x0008_8001 -> ptw_req with addr 0x0001_0014; cache_read with phy 0x0008_8ABC; cpu_done one cycle after cache_stall=0.
- Repeat read to 0x0000_5FF0 -> no ptw_req; cache_read at +2 cycles with phy 0x0008_8FF0.
- Write to a page with PTE=0x0009_9001 (not writable) -> cpu_fault pulse, no cache_write; write to a page with PTE=0x0009_9003 -> cache_write with cache_wdata=cpu_wdata.
- PTE=0x0000_0000 -> cpu_fault; a retry of the same VPN walks again, proving no fill occurred.
- Nine distinct VPNs 0..8 accessed in order (TLB_ENTRIES=8), then VPN 0 again -> VPN 0 misses (evicted at pointer wrap) and VPN 8 hits; tlb_flush in IDLE -> every VPN misses next.
- rst_n low during WALK_WAIT, then ptw_ready pulses -> all outputs 0, state IDLE, prior TLB entries miss.
